mor1kx_tlb_reload_arbiter: RTL and testbench

//  Bus-side servicer for the hardware TLB-reload ports of the IMMU and DMMU.
//  - Takes each MMU's reload request and issues single-word page-table reads on a Wishbone-classic master port.
//  - Returns the read data with a one-cycle ack, which the MMU reload FSMs consume.
//  - Locks the bus to one MMU for its whole walk (PTE pointer read + PTE read).
//  - Bus errors and timeouts return data 0, so the MMU raises a reload pagefault.

---
 rtl/mor1kx_tlb_reload_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mor1kx_tlb_reload_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Services IMMU/DMMU hardware TLB-reload reads on a Wishbone-classic master.
// One MMU owns the bus for its whole page-table walk; errors return zero data.
module mor1kx_tlb_reload_arbiter #(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam logic [31:0] TMO_LAST = 32'(OPTION_TIMEOUT_CYCLES - 1);
    localparam bit TMO_EN = (OPTION_TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          lock_q, lock_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          abort_q, abort_d;
    logic          cyc_q, cyc_d;
    logic [OW-1:2] adr_q, adr_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [OW-1:0] idata_q, idata_d;
    logic [OW-1:0] ddata_q, ddata_d;
    logic          iack_q, iack_d;
    logic          dack_q, dack_d;
    logic          err_q, err_d;

    logic owner_req;
    logic win;
    logic tmo;
    logic fail;
    logic drop;

    assign owner_req = owner_q ? dmmu_req_i : immu_req_i;
    assign tmo       = TMO_EN && (cnt_q == TMO_LAST);
    assign fail      = wbm_err_i || tmo;
    assign drop      = abort_q || !owner_req;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        last_d  = last_q;
        abort_d = abort_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        idata_d = idata_q;
        ddata_d = ddata_q;
        iack_d  = 1'b0;
        dack_d  = 1'b0;
        err_d   = 1'b0;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lock_q && owner_req) begin
                    adr_d   = owner_q ? dmmu_addr_i[OW-1:2]
                                      : immu_addr_i[OW-1:2];
                    cyc_d   = 1'b1;
                    abort_d = 1'b0;
                    state_d = BUS;
                end else begin
                    lock_d = 1'b0;
                    if (immu_req_i || dmmu_req_i) begin
                        // Round-robin: a tie goes to whoever was not last granted.
                        win     = (immu_req_i && dmmu_req_i) ? !last_q
                                                             : dmmu_req_i;
                        lock_d  = 1'b1;
                        owner_d = win;
                        last_d  = win;
                        adr_d   = win ? dmmu_addr_i[OW-1:2]
                                      : immu_addr_i[OW-1:2];
                        cyc_d   = 1'b1;
                        abort_d = 1'b0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                cnt_d   = cnt_q + 32'd1;
                abort_d = drop;
                if (fail || wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RESP;
                    if (!drop) begin
                        err_d = fail;
                        if (owner_q) begin
                            ddata_d = fail ? '0 : wbm_dat_i;
                            dack_d  = 1'b1;
                        end else begin
                            idata_d = fail ? '0 : wbm_dat_i;
                            iack_d  = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (abort_q) begin
                    lock_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                lock_d  = 1'b0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            cnt_q   <= '0;
            idata_q <= '0;
            ddata_q <= '0;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            abort_q <= abort_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            idata_q <= idata_d;
            ddata_q <= ddata_d;
            iack_q  <= iack_d;
            dack_q  <= dack_d;
            err_q   <= err_d;
        end
    end

    assign immu_ack_o  = iack_q;
    assign immu_data_o = idata_q;
    assign dmmu_ack_o  = dack_q;
    assign dmmu_data_o = ddata_q;
    assign wbm_adr_o   = {adr_q, 2'b00};
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hf;
    assign busy_o      = (state_q != IDLE) || lock_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Bench for the TLB-reload arbiter: emulated MMU walkers, a wait-state slave
// and a walk-level reference model of service order and returned data.
module tb_mor1kx_tlb_reload_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_v [2] = '{1'b0, 1'b0};
    logic [31:0] addr_v[2] = '{32'h0, 32'h0};
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [31:0] dat_i = 32'h0;

    logic        immu_ack_o, dmmu_ack_o;
    logic [31:0] immu_data_o, dmmu_data_o, wbm_adr_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, err_o;
    logic [3:0]  wbm_sel_o;

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH (32),
        .OPTION_TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .immu_req_i (req_v[0]),
        .immu_addr_i(addr_v[0]),
        .immu_ack_o (immu_ack_o),
        .immu_data_o(immu_data_o),
        .dmmu_req_i (req_v[1]),
        .dmmu_addr_i(addr_v[1]),
        .dmmu_ack_o (dmmu_ack_o),
        .dmmu_data_o(dmmu_data_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (ack_i),
        .wbm_err_i  (err_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Page-table memory seen by the slave.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0004_2000;
        if (a == 32'h0004_2010) return 32'h0008_4cc0;
        return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Slave: s_wait wait states, optional error replies, optional hang.
    int s_wait = 0;
    bit s_hang = 1'b0;
    int s_err_total = 0;
    int s_err_used = 0;
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!wbm_cyc_o || ack_i || err_i) begin
                ack_i = 1'b0;
                err_i = 1'b0;
                wcnt = 0;
            end else if (wcnt < s_wait) begin
                wcnt++;
            end else if (!s_hang) begin
                if (s_err_used < s_err_total) begin
                    s_err_used++;
                    err_i = 1'b1;
                    dat_i = 32'hdead_beef;
                end else begin
                    ack_i = 1'b1;
                    dat_i = mem_f(wbm_adr_o);
                end
            end
        end
    end

    // MMU walkers: two reads, next address = first PTE + 16.
    int          start_req[2] = '{0, 0};
    int          abort_req[2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          t_start  [2] = '{0, 0};
    logic [31:0] a0_v     [2] = '{32'h0, 32'h0};
    initial begin
        int start_seen[2];
        int abort_seen[2];
        int step[2];
        bit active[2];
        logic ack_m;
        logic [31:0] dat_m;
        start_seen = '{0, 0};
        abort_seen = '{0, 0};
        step = '{0, 0};
        active = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                ack_m = (m == 1) ? dmmu_ack_o : immu_ack_o;
                dat_m = (m == 1) ? dmmu_data_o : immu_data_o;
                if (abort_seen[m] != abort_req[m]) begin
                    abort_seen[m] = abort_req[m];
                    start_seen[m] = start_req[m];
                    req_v[m] = 1'b0;
                    active[m] = 1'b0;
                end else if (active[m]) begin
                    if (ack_m) begin
                        if (step[m] == 0) begin
                            addr_v[m] = dat_m + 32'd16;
                            step[m] = 1;
                        end else begin
                            req_v[m] = 1'b0;
                            active[m] = 1'b0;
                            done_cnt[m]++;
                        end
                    end
                end else if (start_seen[m] != start_req[m]) begin
                    start_seen[m] = start_req[m];
                    req_v[m] = 1'b1;
                    addr_v[m] = a0_v[m];
                    step[m] = 0;
                    active[m] = 1'b1;
                    t_start[m] = cyc_n;
                end
            end
        end
    end

    // Monitor: bus reads, cycle lengths, acks in arrival order.
    logic [31:0] adr_q[$];
    int          len_q[$];
    int          who_q[$];
    logic [31:0] dat_q[$];
    logic        erq_q[$];
    int          t_q[$];
    int          stray_err = 0;
    int          bad_static = 0;
    initial begin
        logic cyc_prev;
        int cur_len;
        cyc_prev = 1'b0;
        cur_len = 0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && !cyc_prev) begin
                adr_q.push_back(wbm_adr_o);
                cur_len = 0;
            end
            if (wbm_cyc_o) cur_len++;
            if (!wbm_cyc_o && cyc_prev) len_q.push_back(cur_len);
            if (immu_ack_o) begin
                who_q.push_back(0);
                dat_q.push_back(immu_data_o);
                erq_q.push_back(err_o);
                t_q.push_back(cyc_n);
            end
            if (dmmu_ack_o) begin
                who_q.push_back(1);
                dat_q.push_back(dmmu_data_o);
                erq_q.push_back(err_o);
                t_q.push_back(cyc_n);
            end
            if (err_o && !immu_ack_o && !dmmu_ack_o) stray_err++;
            if (wbm_stb_o !== wbm_cyc_o || wbm_we_o !== 1'b0 ||
                wbm_sel_o !== 4'hf || wbm_adr_o[1:0] !== 2'b00)
                bad_static++;
            cyc_prev = wbm_cyc_o;
        end
    end

    // Reference model state: who was granted last, last data per MMU.
    int          last_g = 0;
    logic [31:0] last_d[2] = '{32'h0, 32'h0};

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        last_g = 0;
        last_d = '{32'h0, 32'h0};
    endtask

    task automatic run_walks(input bit do_i, input bit do_d,
                             input logic [31:0] ai, input logic [31:0] ad,
                             input int nerr, output int bk);
        int ba;
        int e;
        int order[$];
        int tgt[2];
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        int ew[$];
        logic ee[$];
        logic [31:0] a0[2];
        logic [31:0] a;
        logic [31:0] d;
        ba = adr_q.size();
        bk = who_q.size();
        e = nerr;
        a0[0] = ai;
        a0[1] = ad;
        if (do_i && do_d) begin
            order.push_back(1 - last_g);
            order.push_back(last_g);
        end else if (do_i) begin
            order.push_back(0);
        end else begin
            order.push_back(1);
        end
        last_g = order[order.size() - 1];
        foreach (order[k]) begin
            a = a0[order[k]];
            for (int r = 0; r < 2; r++) begin
                ea.push_back(a & 32'hffff_fffc);
                if (e > 0) begin
                    d = 32'h0;
                    e--;
                    ee.push_back(1'b1);
                end else begin
                    d = mem_f(a & 32'hffff_fffc);
                    ee.push_back(1'b0);
                end
                ed.push_back(d);
                ew.push_back(order[k]);
                a = d + 32'd16;
            end
            last_d[order[k]] = d;
        end
        @(posedge clk); #1;
        if (!s_hang) s_err_total = s_err_used + nerr;
        a0_v[0] = ai;
        a0_v[1] = ad;
        tgt[0] = done_cnt[0] + (do_i ? 1 : 0);
        tgt[1] = done_cnt[1] + (do_d ? 1 : 0);
        if (do_i) start_req[0]++;
        if (do_d) start_req[1]++;
        for (int c = 0; c < 600; c++) begin
            if (done_cnt[0] == tgt[0] && done_cnt[1] == tgt[1]) break;
            @(negedge clk);
        end
        chk("walk_done_immu", 32'(done_cnt[0]), 32'(tgt[0]));
        chk("walk_done_dmmu", 32'(done_cnt[1]), 32'(tgt[1]));
        repeat (2) @(negedge clk);
        chk("n_reads", 32'(adr_q.size() - ba), 32'(ea.size()));
        chk("n_acks", 32'(who_q.size() - bk), 32'(ew.size()));
        foreach (ea[i]) begin
            if (ba + i < adr_q.size())
                chk($sformatf("bus_adr%0d", i), adr_q[ba + i], ea[i]);
            if (bk + i < who_q.size()) begin
                chk($sformatf("ack_who%0d", i), 32'(who_q[bk + i]), 32'(ew[i]));
                chk($sformatf("ack_dat%0d", i), dat_q[bk + i], ed[i]);
                chk($sformatf("ack_err%0d", i), 32'(erq_q[bk + i]), 32'(ee[i]));
            end
        end
        chk("immu_data_hold", immu_data_o, last_d[0]);
        chk("dmmu_data_hold", dmmu_data_o, last_d[1]);
        chk("busy_idle", 32'(busy_o), 32'h0);
    endtask

    initial begin
        int bk;
        int lb;
        int pick;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({immu_ack_o, dmmu_ack_o, wbm_cyc_o, wbm_stb_o,
                             wbm_we_o, busy_o, err_o}), 32'h0);
        chk("rst_idata", immu_data_o, 32'h0);
        chk("rst_ddata", dmmu_data_o, 32'h0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DMMU walk, zero-wait slave, with latency
        s_wait = 0;
        run_walks(1'b0, 1'b1, 32'h0, 32'h1000, 0, bk);
        chk("walk_pte", dmmu_data_o, 32'h0008_4cc0);
        if (bk + 1 < t_q.size()) begin
            chk("lat_first_ack", 32'(t_q[bk] - t_start[1]), 32'd2);
            chk("lat_walk_end", 32'(t_q[bk + 1] - t_start[1]), 32'd5);
        end

        // Simultaneous requests from reset: DMMU first, no interleaving
        do_reset();
        run_walks(1'b1, 1'b1, 32'h0000_8000, 32'h0000_1000, 0, bk);

        // Bus error on first read; lock held through the walk
        s_wait = 1;
        run_walks(1'b1, 1'b1, 32'h0000_9000, 32'h0000_a000, 1, bk);

        // Hung slave: both reads time out after 8 bus cycles
        s_hang = 1'b1;
        lb = len_q.size();
        run_walks(1'b0, 1'b1, 32'h0, 32'h0000_b000, 2, bk);
        s_hang = 1'b0;
        if (lb + 1 < len_q.size()) begin
            chk("tmo_len0", 32'(len_q[lb]), 32'd8);
            chk("tmo_len1", 32'(len_q[lb + 1]), 32'd8);
        end

        // Abort: req drops during a 5-wait-state read
        s_wait = 5;
        bk = who_q.size();
        a0_v[1] = 32'h0000_2000;
        @(posedge clk); #1;
        start_req[1]++;
        for (int c = 0; c < 20; c++) begin
            if (wbm_cyc_o) break;
            @(negedge clk);
        end
        chk("abort_cyc", 32'(wbm_cyc_o), 32'h1);
        @(posedge clk); #1;
        abort_req[1]++;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            if (ack_i) break;
        end
        chk("abort_bus_ack", 32'(ack_i), 32'h1);
        @(negedge clk);
        chk("abort_busy1", 32'(busy_o), 32'h1);
        chk("abort_noack1", 32'({dmmu_ack_o, err_o}), 32'h0);
        @(negedge clk);
        chk("abort_busy0", 32'(busy_o), 32'h0);
        chk("abort_noack2", 32'({dmmu_ack_o, err_o}), 32'h0);
        chk("abort_nacks", 32'(who_q.size() - bk), 32'h0);
        chk("abort_ddata", dmmu_data_o, last_d[1]);
        last_g = 1;
        s_wait = 0;

        // Reset while cyc is high
        s_hang = 1'b1;
        a0_v[1] = 32'h0000_3000;
        @(posedge clk); #1;
        start_req[1]++;
        for (int c = 0; c < 20; c++) begin
            if (wbm_cyc_o) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("prerst_cyc", 32'(wbm_cyc_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_async_bus", 32'({wbm_cyc_o, wbm_stb_o}), 32'h0);
        chk("rst_async_ack", 32'({immu_ack_o, dmmu_ack_o, busy_o}), 32'h0);
        abort_req[1]++;
        s_hang = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        last_g = 0;
        last_d = '{32'h0, 32'h0};
        run_walks(1'b0, 1'b1, 32'h0000_4004, 32'h0000_4004, 0, bk);

        // Randomized walks
        for (int it = 0; it < 20; it++) begin
            s_wait = $urandom_range(0, 6);
            pick = $urandom_range(0, 2);
            run_walks(pick != 1, pick != 0, $urandom, $urandom,
                      ($urandom_range(0, 3) == 0) ? 1 : 0, bk);
        end

        chk("stray_err", 32'(stray_err), 32'h0);
        chk("bus_static", 32'(bad_static), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
